// File: rtl/timer_regs_pkg.sv
// Shared constants and field layouts for the timer register bank.
// Holds the register address map, the CTRL/CTRL_IN/CTRL_OUT bit positions
// and the reset values used by timer_registers_mc and timer_preload_reg.
package timer_regs_pkg;

  localparam int unsigned ADDR_W = 6;

  // Register address map
  localparam logic [ADDR_W-1:0] ADDR_CTRL       = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_CTRL_IN    = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_CTRL_OUT   = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_TRG_EN     = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_INT_EN     = 6'h05;
  localparam logic [ADDR_W-1:0] ADDR_CNT_INIT   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_CNT_MIN    = 6'h09;
  localparam logic [ADDR_W-1:0] ADDR_CNT_MAX    = 6'h0A;
  localparam logic [ADDR_W-1:0] ADDR_CNT        = 6'h0B;
  localparam logic [ADDR_W-1:0] MATCH_BASE_ADDR = 6'h10;

  // CTRL bit positions
  localparam int unsigned CTRL_START_BIT      = 0;
  localparam int unsigned CTRL_COUNT_MODE_BIT = 1;
  localparam int unsigned CTRL_PRELOAD_BIT    = 2;
  localparam int unsigned CTRL_CLK_SEL_BIT    = 3;
  localparam int unsigned CTRL_FORCE_FREE_BIT = 7;

  // CTRL_IN bit positions
  localparam int unsigned CTRL_IN_EDGE_BIT  = 0;
  localparam int unsigned CTRL_IN_PRESC_LSB = 4;

  // CTRL_OUT bit positions
  localparam int unsigned CTRL_OUT_PWM_BIT     = 0;
  localparam int unsigned CTRL_OUT_INV_BIT     = 1;
  localparam int unsigned CTRL_OUT_OVF_TRG_BIT = 4;

  typedef struct packed {
    logic force_free;
    logic clock_select;
    logic preload_en;
    logic count_mode;
    logic start;
  } ctrl_t;

  typedef struct packed {
    logic overflow_trg_en;
    logic inv;
    logic pwm_mode;
  } ctrl_out_t;

  // Reset values
  localparam ctrl_t     CTRL_RST      = '0;
  localparam ctrl_out_t CTRL_OUT_RST  = '0;
  localparam logic      EDGE_MODE_RST = 1'b0;
  // CNT_MAX resets to all ones; replicated to the counter width at use
  localparam logic      MAX_RST_FILL  = 1'b1;

endpackage

// File: rtl/timer_preload_reg.sv
// Double-buffered register: a bus-visible shadow copy and an active copy
// that drives the datapath.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   wr, wdata   write strobe and data for the shadow copy
//   preload_en  1 = writes only reach the shadow until the next update
//   update      transfer pulse (counter overflow)
//   shadow      bus-visible value (read-back)
//   active      value in use by the datapath
module timer_preload_reg #(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         preload_en,
  input  logic         update,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);

  // The active copy loads the shadow value as it was before this edge, so a
  // write coinciding with an update is held back until the following update.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RST_VAL;
      active <= RST_VAL;
    end else begin
      if (wr) begin
        shadow <= wdata;
      end
      if (wr && !preload_en) begin
        active <= wdata;
      end else if (preload_en && update) begin
        active <= shadow;
      end
    end
  end

endmodule

// File: rtl/timer_registers_mc.sv
// Register bank for the multi-channel timer core.
// Decodes bus accesses, holds configuration, preloaded MAX/MATCH values and
// sticky overflow/match status, and raises an aggregated interrupt.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   module_en, wr, addr,
//   wdata, rdata, rvalid      bus slave side (1-cycle registered read)
//   count_value, overflow,
//   match                     events and live count from the datapath
//   start ... match_value     configuration driven to the datapath
//   cnt_init_wr               pulse the cycle after a CNT_INIT write
//   overflow_status,
//   match_status, irq         sticky flags and interrupt request
module timer_registers_mc
  import timer_regs_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE  = 32,
  parameter int unsigned PRESCALER_BIT = 3,
  parameter int unsigned NUM_CH        = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           module_en,
  input  logic                           wr,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [COUNTER_SIZE-1:0]        wdata,
  output logic [COUNTER_SIZE-1:0]        rdata,
  output logic                           rvalid,
  input  logic [COUNTER_SIZE-1:0]        count_value,
  input  logic                           overflow,
  input  logic [NUM_CH-1:0]              match,
  output logic                           start,
  output logic                           count_mode,
  output logic                           clock_select,
  output logic                           force_free,
  output logic                           preload_en,
  output logic [PRESCALER_BIT-1:0]       prescaler,
  output logic                           edge_mode,
  output logic                           pwm_mode,
  output logic                           inv,
  output logic                           overflow_trg_en,
  output logic [NUM_CH-1:0]              match_trg_en,
  output logic [COUNTER_SIZE-1:0]        count_init,
  output logic [COUNTER_SIZE-1:0]        count_min,
  output logic [COUNTER_SIZE-1:0]        count_max,
  output logic [NUM_CH*COUNTER_SIZE-1:0] match_value,
  output logic                           cnt_init_wr,
  output logic                           overflow_status,
  output logic [NUM_CH-1:0]              match_status,
  output logic                           irq
);

  localparam int unsigned ST_W = NUM_CH + 1;

  ctrl_t                     ctrl_q;
  ctrl_out_t                 ctrl_out_q;
  logic                      edge_mode_q;
  logic [PRESCALER_BIT-1:0]  prescaler_q;
  logic [NUM_CH-1:0]         trg_en_q;
  logic [ST_W-1:0]           int_en_q;
  logic [ST_W-1:0]           status_q;
  logic [COUNTER_SIZE-1:0]   cnt_init_q;
  logic [COUNTER_SIZE-1:0]   cnt_min_q;
  logic                      cnt_init_wr_q;
  logic [COUNTER_SIZE-1:0]   rdata_q;
  logic                      rvalid_q;
  logic [COUNTER_SIZE-1:0]   max_shadow;
  logic [COUNTER_SIZE-1:0]   match_shadow [NUM_CH];

  logic                      wr_en_c;
  logic                      rd_en_c;
  logic                      max_wr_c;
  logic [NUM_CH-1:0]         match_wr_c;
  logic [ST_W-1:0]           status_set_c;
  logic [ST_W-1:0]           status_clr_c;
  logic [COUNTER_SIZE-1:0]   rd_data_c;

  assign wr_en_c  = module_en && wr;
  assign rd_en_c  = module_en && !wr;
  assign max_wr_c = wr_en_c && (addr == ADDR_CNT_MAX);

  // Match flags only count while the timer runs; overflow is always captured
  assign status_set_c = {match & {NUM_CH{ctrl_q.start}}, overflow};
  assign status_clr_c = (wr_en_c && (addr == ADDR_STATUS)) ? wdata[ST_W-1:0] : '0;

  // Configuration and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q        <= CTRL_RST;
      ctrl_out_q    <= CTRL_OUT_RST;
      edge_mode_q   <= EDGE_MODE_RST;
      prescaler_q   <= '0;
      trg_en_q      <= '0;
      int_en_q      <= '0;
      status_q      <= '0;
      cnt_init_q    <= '0;
      cnt_min_q     <= '0;
      cnt_init_wr_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        case (addr)
          ADDR_CTRL: begin
            ctrl_q.start        <= wdata[CTRL_START_BIT];
            ctrl_q.count_mode   <= wdata[CTRL_COUNT_MODE_BIT];
            ctrl_q.preload_en   <= wdata[CTRL_PRELOAD_BIT];
            ctrl_q.clock_select <= wdata[CTRL_CLK_SEL_BIT];
            ctrl_q.force_free   <= wdata[CTRL_FORCE_FREE_BIT];
          end
          ADDR_CTRL_IN: begin
            edge_mode_q <= wdata[CTRL_IN_EDGE_BIT];
            prescaler_q <= wdata[CTRL_IN_PRESC_LSB +: PRESCALER_BIT];
          end
          ADDR_CTRL_OUT: begin
            ctrl_out_q.pwm_mode        <= wdata[CTRL_OUT_PWM_BIT];
            ctrl_out_q.inv             <= wdata[CTRL_OUT_INV_BIT];
            ctrl_out_q.overflow_trg_en <= wdata[CTRL_OUT_OVF_TRG_BIT];
          end
          ADDR_TRG_EN:   trg_en_q   <= wdata[NUM_CH-1:0];
          ADDR_INT_EN:   int_en_q   <= wdata[ST_W-1:0];
          ADDR_CNT_INIT: cnt_init_q <= wdata;
          ADDR_CNT_MIN:  cnt_min_q  <= wdata;
          default: ;
        endcase
      end
      // Set has priority over a same-cycle W1C clear
      status_q      <= status_set_c | (status_q & ~status_clr_c);
      cnt_init_wr_q <= wr_en_c && (addr == ADDR_CNT_INIT);
    end
  end

  // Preloaded MAX register
  timer_preload_reg #(
    .W       (COUNTER_SIZE),
    .RST_VAL ({COUNTER_SIZE{MAX_RST_FILL}})
  ) u_max (
    .clk        (clk),
    .rst        (rst),
    .wr         (max_wr_c),
    .wdata      (wdata),
    .preload_en (ctrl_q.preload_en),
    .update     (overflow),
    .shadow     (max_shadow),
    .active     (count_max)
  );

  // Preloaded MATCH registers, one per channel
  for (genvar k = 0; k < NUM_CH; k++) begin : g_match
    assign match_wr_c[k] = wr_en_c && (addr == MATCH_BASE_ADDR + ADDR_W'(k));

    timer_preload_reg #(
      .W       (COUNTER_SIZE),
      .RST_VAL ('0)
    ) u_match (
      .clk        (clk),
      .rst        (rst),
      .wr         (match_wr_c[k]),
      .wdata      (wdata),
      .preload_en (ctrl_q.preload_en),
      .update     (overflow),
      .shadow     (match_shadow[k]),
      .active     (match_value[k*COUNTER_SIZE +: COUNTER_SIZE])
    );
  end

  // Read mux; unmapped addresses and undefined bits return zero
  always_comb begin
    rd_data_c = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_data_c[CTRL_START_BIT]      = ctrl_q.start;
        rd_data_c[CTRL_COUNT_MODE_BIT] = ctrl_q.count_mode;
        rd_data_c[CTRL_PRELOAD_BIT]    = ctrl_q.preload_en;
        rd_data_c[CTRL_CLK_SEL_BIT]    = ctrl_q.clock_select;
        rd_data_c[CTRL_FORCE_FREE_BIT] = ctrl_q.force_free;
      end
      ADDR_CTRL_IN: begin
        rd_data_c[CTRL_IN_EDGE_BIT]                   = edge_mode_q;
        rd_data_c[CTRL_IN_PRESC_LSB +: PRESCALER_BIT] = prescaler_q;
      end
      ADDR_CTRL_OUT: begin
        rd_data_c[CTRL_OUT_PWM_BIT]     = ctrl_out_q.pwm_mode;
        rd_data_c[CTRL_OUT_INV_BIT]     = ctrl_out_q.inv;
        rd_data_c[CTRL_OUT_OVF_TRG_BIT] = ctrl_out_q.overflow_trg_en;
      end
      ADDR_TRG_EN:   rd_data_c[NUM_CH-1:0] = trg_en_q;
      ADDR_STATUS:   rd_data_c[ST_W-1:0]   = status_q;
      ADDR_INT_EN:   rd_data_c[ST_W-1:0]   = int_en_q;
      ADDR_CNT_INIT: rd_data_c = cnt_init_q;
      ADDR_CNT_MIN:  rd_data_c = cnt_min_q;
      ADDR_CNT_MAX:  rd_data_c = max_shadow;
      ADDR_CNT:      rd_data_c = count_value;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr == MATCH_BASE_ADDR + ADDR_W'(k)) begin
            rd_data_c = match_shadow[k];
          end
        end
      end
    endcase
  end

  // Registered read response, valid for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (rd_en_c) begin
      rdata_q  <= rd_data_c;
      rvalid_q <= 1'b1;
    end else begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end
  end

  assign rdata           = rdata_q;
  assign rvalid          = rvalid_q;
  assign start           = ctrl_q.start;
  assign count_mode      = ctrl_q.count_mode;
  assign clock_select    = ctrl_q.clock_select;
  assign force_free      = ctrl_q.force_free;
  assign preload_en      = ctrl_q.preload_en;
  assign prescaler       = prescaler_q;
  assign edge_mode       = edge_mode_q;
  assign pwm_mode        = ctrl_out_q.pwm_mode;
  assign inv             = ctrl_out_q.inv;
  assign overflow_trg_en = ctrl_out_q.overflow_trg_en;
  assign match_trg_en    = trg_en_q;
  assign count_init      = cnt_init_q;
  assign count_min       = cnt_min_q;
  assign cnt_init_wr     = cnt_init_wr_q;
  assign overflow_status = status_q[0];
  assign match_status    = status_q[ST_W-1:1];

  // Decoded from flops only, so it follows the setting event by one cycle
  assign irq = |(status_q & int_en_q);

endmodule

// File: tb/tb_timer_registers_mc.sv
module tb_timer_registers_mc;

  localparam int unsigned CS = 32;
  localparam int unsigned PB = 3;
  localparam int unsigned NC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              module_en;
  logic              wr;
  logic [5:0]        addr;
  logic [CS-1:0]     wdata;
  logic [CS-1:0]     rdata;
  logic              rvalid;
  logic [CS-1:0]     count_value;
  logic              overflow;
  logic [NC-1:0]     match;
  logic              start, count_mode, clock_select, force_free, preload_en;
  logic [PB-1:0]     prescaler;
  logic              edge_mode, pwm_mode, inv, overflow_trg_en;
  logic [NC-1:0]     match_trg_en;
  logic [CS-1:0]     count_init, count_min, count_max;
  logic [NC*CS-1:0]  match_value;
  logic              cnt_init_wr, overflow_status;
  logic [NC-1:0]     match_status;
  logic              irq;

  int checks = 0;
  int errors = 0;

  timer_registers_mc #(
    .COUNTER_SIZE  (CS),
    .PRESCALER_BIT (PB),
    .NUM_CH        (NC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .module_en       (module_en),
    .wr              (wr),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .count_value     (count_value),
    .overflow        (overflow),
    .match           (match),
    .start           (start),
    .count_mode      (count_mode),
    .clock_select    (clock_select),
    .force_free      (force_free),
    .preload_en      (preload_en),
    .prescaler       (prescaler),
    .edge_mode       (edge_mode),
    .pwm_mode        (pwm_mode),
    .inv             (inv),
    .overflow_trg_en (overflow_trg_en),
    .match_trg_en    (match_trg_en),
    .count_init      (count_init),
    .count_min       (count_min),
    .count_max       (count_max),
    .match_value     (match_value),
    .cnt_init_wr     (cnt_init_wr),
    .overflow_status (overflow_status),
    .match_status    (match_status),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [CS-1:0] d);
    module_en = 1'b1; wr = 1'b1; addr = a; wdata = d;
    step();
    module_en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [CS-1:0] d, output logic v);
    module_en = 1'b1; wr = 1'b0; addr = a;
    step();
    module_en = 1'b0;
    d = rdata;
    v = rvalid;
  endtask

  // ---------------- reference model (register-level view) ----------------
  logic [CS-1:0] m_ctrl, m_ctrl_in, m_ctrl_out, m_trg, m_int, m_init, m_min;
  logic [CS-1:0] m_max_sh, m_max_act;
  logic [CS-1:0] m_msh [NC];
  logic [CS-1:0] m_mact [NC];
  logic [2:0]    m_st;

  task automatic model_reset();
    m_ctrl = '0; m_ctrl_in = '0; m_ctrl_out = '0; m_trg = '0; m_int = '0;
    m_init = '0; m_min = '0; m_max_sh = '1; m_max_act = '1; m_st = '0;
    for (int k = 0; k < NC; k++) begin
      m_msh[k] = '0;
      m_mact[k] = '0;
    end
  endtask

  function automatic logic [CS-1:0] model_read(input logic [5:0] a, input logic [CS-1:0] cv);
    case (a)
      6'h00: return m_ctrl;
      6'h01: return m_ctrl_in;
      6'h02: return m_ctrl_out;
      6'h03: return m_trg;
      6'h04: return {29'd0, m_st};
      6'h05: return m_int;
      6'h08: return m_init;
      6'h09: return m_min;
      6'h0A: return m_max_sh;
      6'h0B: return cv;
      6'h10: return m_msh[0];
      6'h11: return m_msh[1];
      default: return '0;
    endcase
  endfunction

  // ---------------- directed tests ----------------
  task automatic test_reset();
    logic [5:0]    ra [14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                               6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11, 6'h07, 6'h12};
    logic [CS-1:0] d;
    logic          v;
    logic [CS-1:0] exp_d;
    rst = 1'b1; module_en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    overflow = 1'b0; match = '0; count_value = 32'h0000_1234;
    step();
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    checks++; if (count_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_count_max got %h exp ffffffff", count_max); end
    checks++; if ({overflow_status, match_status, irq, cnt_init_wr} !== 5'b0) begin
      errors++; $display("FAIL reset_status got %b exp 00000", {overflow_status, match_status, irq, cnt_init_wr}); end
    checks++; if ({match_value, count_init, count_min} !== '0) begin errors++; $display("FAIL reset_values got nonzero exp 0"); end
    checks++; if ({start, count_mode, clock_select, force_free, preload_en, prescaler, edge_mode,
                   pwm_mode, inv, overflow_trg_en, match_trg_en} !== '0) begin
      errors++; $display("FAIL reset_ctrl got nonzero exp 0"); end
    rst = 1'b0;
    foreach (ra[i]) begin
      exp_d = (ra[i] == 6'h0A) ? 32'hFFFF_FFFF : (ra[i] == 6'h0B) ? 32'h0000_1234 : 32'h0;
      bus_read(ra[i], d, v);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL read_rvalid addr %h got %b exp 1", ra[i], v); end
      checks++; if (d !== exp_d) begin errors++; $display("FAIL read_reset addr %h got %h exp %h", ra[i], d, exp_d); end
      step();
      checks++; if ({rvalid, rdata} !== 33'b0) begin errors++; $display("FAIL rvalid_pulse addr %h got %b exp 0", ra[i], rvalid); end
    end
  endtask

  task automatic test_preload_match();
    logic [CS-1:0] d;
    logic          v;
    bus_write(6'h11, 32'h55);
    checks++; if (match_value[63:32] !== 32'h55) begin errors++; $display("FAIL match1_direct got %h exp 00000055", match_value[63:32]); end
    bus_write(6'h00, 32'h4);
    bus_write(6'h11, 32'hAA);
    checks++; if (match_value[63:32] !== 32'h55) begin errors++; $display("FAIL match1_held got %h exp 00000055", match_value[63:32]); end
    bus_read(6'h11, d, v);
    checks++; if (d !== 32'hAA) begin errors++; $display("FAIL match1_shadow_read got %h exp 000000aa", d); end
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    checks++; if (match_value[63:32] !== 32'hAA) begin errors++; $display("FAIL match1_loaded got %h exp 000000aa", match_value[63:32]); end
  endtask

  task automatic test_preload_max();
    overflow = 1'b1;
    bus_write(6'h0A, 32'h100);
    overflow = 1'b0;
    checks++; if (count_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_same_cycle got %h exp ffffffff", count_max); end
    step();
    checks++; if (count_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_no_ovf got %h exp ffffffff", count_max); end
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    checks++; if (count_max !== 32'h100) begin errors++; $display("FAIL max_loaded got %h exp 00000100", count_max); end
  endtask

  task automatic test_status_irq();
    bus_write(6'h04, 32'h7);
    bus_write(6'h00, 32'h5);
    bus_write(6'h05, 32'h4);
    checks++; if ({match_status, overflow_status, irq} !== 4'b0) begin
      errors++; $display("FAIL status_cleared got %b exp 0000", {match_status, overflow_status, irq}); end
    match = 2'b10;
    step();
    match = 2'b00;
    checks++; if (match_status !== 2'b10 || irq !== 1'b1) begin
      errors++; $display("FAIL match1_set got ms=%b irq=%b exp ms=10 irq=1", match_status, irq); end
    match = 2'b10;
    bus_write(6'h04, 32'h4);
    match = 2'b00;
    checks++; if (match_status !== 2'b10) begin errors++; $display("FAIL set_beats_clear got %b exp 10", match_status); end
    bus_write(6'h04, 32'h4);
    checks++; if (match_status !== 2'b00 || irq !== 1'b0) begin
      errors++; $display("FAIL w1c_clear got ms=%b irq=%b exp ms=00 irq=0", match_status, irq); end
  endtask

  task automatic test_start_gating();
    bus_write(6'h04, 32'h7);
    bus_write(6'h00, 32'h4);
    match = 2'b01;
    step();
    match = 2'b00;
    checks++; if (match_status !== 2'b00) begin errors++; $display("FAIL match_no_start got %b exp 00", match_status); end
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    checks++; if (overflow_status !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_status); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_masked got %b exp 0", irq); end
  endtask

  task automatic test_back_to_back();
    module_en = 1'b1; wr = 1'b1; addr = 6'h08; wdata = 32'h10;
    step();
    checks++; if (cnt_init_wr !== 1'b1) begin errors++; $display("FAIL cnt_init_wr_c1 got %b exp 1", cnt_init_wr); end
    step();
    module_en = 1'b0; wr = 1'b0;
    checks++; if (cnt_init_wr !== 1'b1 || count_init !== 32'h10) begin
      errors++; $display("FAIL cnt_init_wr_c2 got %b/%h exp 1/00000010", cnt_init_wr, count_init); end
    step();
    checks++; if (cnt_init_wr !== 1'b0) begin errors++; $display("FAIL cnt_init_wr_c3 got %b exp 0", cnt_init_wr); end
    // Set a match flag too, then reset with a read in flight
    bus_write(6'h00, 32'h1);
    match = 2'b11;
    step();
    match = 2'b00;
    module_en = 1'b1; wr = 1'b0; addr = 6'h0A; rst = 1'b1;
    step();
    module_en = 1'b0; rst = 1'b0;
    checks++; if ({rvalid, overflow_status, match_status} !== 4'b0) begin
      errors++; $display("FAIL reset_inflight got %b exp 0000", {rvalid, overflow_status, match_status}); end
    checks++; if (count_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_inflight_max got %h exp ffffffff", count_max); end
  endtask

  // ---------------- randomized test against the model ----------------
  task automatic test_random();
    logic [5:0]    pool [16] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h04, 6'h05,
                                 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10, 6'h11, 6'h12};
    int unsigned   op;
    logic [5:0]    a;
    logic [CS-1:0] d, cv, e_rdata, old_sh;
    logic          e_rvalid, e_ciw, ovf, we, pe, st_en;
    logic [NC-1:0] mt;
    logic [2:0]    clr;
    logic          wmatch;
    rst = 1'b1; module_en = 1'b0; wr = 1'b0; overflow = 1'b0; match = '0;
    step();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      op  = $urandom_range(0, 3);
      a   = pool[$urandom_range(0, 15)];
      d   = $urandom;
      cv  = $urandom;
      ovf = ($urandom_range(0, 3) == 0);
      mt  = NC'($urandom_range(0, 3));
      module_en = (op != 0); wr = (op >= 2); addr = a; wdata = d;
      count_value = cv; overflow = ovf; match = mt;
      // expected results of this edge
      we       = (op >= 2);
      e_rvalid = (op == 1);
      e_rdata  = e_rvalid ? model_read(a, cv) : '0;
      e_ciw    = we && (a == 6'h08);
      pe       = m_ctrl[2];
      st_en    = m_ctrl[0];
      clr      = (we && a == 6'h04) ? d[2:0] : 3'b0;
      m_st     = (m_st & ~clr) | {mt & {NC{st_en}}, ovf};
      old_sh = m_max_sh;
      if (we && a == 6'h0A) begin
        m_max_sh = d;
        if (!pe) m_max_act = d;
      end
      if (pe && ovf) m_max_act = old_sh;
      for (int k = 0; k < NC; k++) begin
        old_sh = m_msh[k];
        wmatch = we && (a == 6'(6'h10 + k));
        if (wmatch) begin
          m_msh[k] = d;
          if (!pe) m_mact[k] = d;
        end
        if (pe && ovf) m_mact[k] = old_sh;
      end
      if (we) begin
        case (a)
          6'h00: m_ctrl     = d & 32'h8F;
          6'h01: m_ctrl_in  = d & 32'h71;
          6'h02: m_ctrl_out = d & 32'h13;
          6'h03: m_trg      = d & 32'h3;
          6'h05: m_int      = d & 32'h7;
          6'h08: m_init     = d;
          6'h09: m_min      = d;
          default: ;
        endcase
      end
      step();
      checks++; if (rvalid !== e_rvalid) begin errors++; $display("FAIL rnd_rvalid n=%0d got %b exp %b", n, rvalid, e_rvalid); end
      checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d addr %h got %h exp %h", n, a, rdata, e_rdata); end
      checks++; if (count_max !== m_max_act) begin errors++; $display("FAIL rnd_count_max n=%0d got %h exp %h", n, count_max, m_max_act); end
      checks++; if (match_value !== {m_mact[1], m_mact[0]}) begin
        errors++; $display("FAIL rnd_match_value n=%0d got %h exp %h", n, match_value, {m_mact[1], m_mact[0]}); end
      checks++; if ({match_status, overflow_status} !== m_st) begin
        errors++; $display("FAIL rnd_status n=%0d got %b exp %b", n, {match_status, overflow_status}, m_st); end
      checks++; if (irq !== (|(m_st & m_int[2:0]))) begin errors++; $display("FAIL rnd_irq n=%0d got %b exp %b", n, irq, |(m_st & m_int[2:0])); end
      checks++; if (cnt_init_wr !== e_ciw) begin errors++; $display("FAIL rnd_cnt_init_wr n=%0d got %b exp %b", n, cnt_init_wr, e_ciw); end
      checks++; if ({force_free, clock_select, preload_en, count_mode, start} !==
                    {m_ctrl[7], m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}) begin
        errors++; $display("FAIL rnd_ctrl n=%0d got %b exp %b", n, {force_free, clock_select, preload_en, count_mode, start},
                           {m_ctrl[7], m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}); end
      checks++; if ({prescaler, edge_mode, overflow_trg_en, inv, pwm_mode, match_trg_en} !==
                    {m_ctrl_in[6:4], m_ctrl_in[0], m_ctrl_out[4], m_ctrl_out[1:0], m_trg[1:0]}) begin
        errors++; $display("FAIL rnd_ctrl_io n=%0d got %b exp %b", n, {prescaler, edge_mode, overflow_trg_en, inv, pwm_mode, match_trg_en},
                           {m_ctrl_in[6:4], m_ctrl_in[0], m_ctrl_out[4], m_ctrl_out[1:0], m_trg[1:0]}); end
      checks++; if (count_init !== m_init || count_min !== m_min) begin
        errors++; $display("FAIL rnd_init_min n=%0d got %h/%h exp %h/%h", n, count_init, count_min, m_init, m_min); end
    end
    module_en = 1'b0; wr = 1'b0; overflow = 1'b0; match = '0;
  endtask

  initial begin
    test_reset();
    test_preload_match();
    test_preload_max();
    test_status_irq();
    test_start_gating();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
